// File: rtl/ram_pkg.sv
// Shared types for the RAM request queue: request op, queued request entry and issue-FSM state.
package ram_pkg;

    localparam int unsigned AddrW = 24;
    localparam int unsigned DataW = 16;

    typedef enum logic {
        OpWr = 1'b0,
        OpRd = 1'b1
    } ram_op_t;

    typedef struct packed {
        ram_op_t            op;
        logic [AddrW-1:0]   addr;
        logic [DataW-1:0]   data;
    } ram_req_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRd,
        StReturn
    } ram_state_t;

endpackage

// File: rtl/ram_req_queue_if.sv
// Request/read-return bus used on both the CPU side and the SDRAM-controller side.
interface ram_req_queue_if;
    import ram_pkg::*;

    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wr_data;
    logic             wr_en;
    logic             rd_en;
    logic             busy;
    logic [DataW-1:0] rd_data;
    logic             rd_ready;
    logic             rd_ack;

    modport master (
        output addr, wr_data, wr_en, rd_en, rd_ack,
        input  busy, rd_data, rd_ready
    );

    modport slave (
        input  addr, wr_data, wr_en, rd_en, rd_ack,
        output busy, rd_data, rd_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] storage_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Occupancy never exceeds Depth, so the MSB is set only when full.
    assign full_o  = count_q[PtrW];
    assign empty_o = (count_q == '0);
    assign rdata_o = storage_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            storage_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ram_req_queue.sv
// Queues CPU read/write requests and issues them in order to the SDRAM controller,
// returning read data to the CPU through a ready/ack handshake.
module ram_req_queue
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_req_queue_if.slave  cpu,
    ram_req_queue_if.master mem
);

    ram_req_t                     push_req;
    ram_req_t                     head_req;
    logic [$bits(ram_req_t)-1:0]  head_bits;
    logic                         fifo_full, fifo_empty, fifo_pop;
    logic                         req_accept, cpu_busy;

    ram_state_t       state_q, state_d;
    logic             rd_pending_q, rd_pending_d;
    logic [AddrW-1:0] mem_addr_q, mem_addr_d;
    logic [DataW-1:0] mem_wr_data_q, mem_wr_data_d;
    logic             mem_wr_en_q, mem_wr_en_d;
    logic             mem_rd_en_q, mem_rd_en_d;
    logic             mem_rd_ack_q, mem_rd_ack_d;
    logic [DataW-1:0] cpu_rd_data_q, cpu_rd_data_d;
    logic             cpu_rd_ready_q, cpu_rd_ready_d;

    // Busy comes only from registered state; an outstanding read blocks all new requests.
    assign cpu_busy   = fifo_full | rd_pending_q;
    assign req_accept = (cpu.wr_en | cpu.rd_en) & ~cpu_busy;
    assign fifo_pop   = (state_q == StIssue);
    assign head_req   = ram_req_t'(head_bits);

    always_comb begin
        push_req.op   = cpu.wr_en ? OpWr : OpRd;
        push_req.addr = cpu.addr;
        push_req.data = cpu.wr_data;
    end

    sync_fifo #(
        .Width ($bits(ram_req_t)),
        .Depth (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (req_accept),
        .wdata_i (push_req),
        .pop_i   (fifo_pop),
        .rdata_o (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d        = state_q;
        rd_pending_d   = rd_pending_q;
        mem_addr_d     = mem_addr_q;
        mem_wr_data_d  = mem_wr_data_q;
        mem_wr_en_d    = 1'b0;
        mem_rd_en_d    = 1'b0;
        mem_rd_ack_d   = 1'b0;
        cpu_rd_data_d  = cpu_rd_data_q;
        cpu_rd_ready_d = cpu_rd_ready_q;

        // A read strobe together with a write strobe is discarded.
        if (req_accept && !cpu.wr_en) begin
            rd_pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !mem.busy) begin
                    state_d       = StIssue;
                    mem_addr_d    = head_req.addr;
                    mem_wr_data_d = head_req.data;
                    mem_wr_en_d   = (head_req.op == OpWr);
                    mem_rd_en_d   = (head_req.op == OpRd);
                end
            end
            StIssue: begin
                state_d = mem_rd_en_q ? StWaitRd : StIdle;
            end
            StWaitRd: begin
                if (mem.rd_ready) begin
                    state_d        = StReturn;
                    cpu_rd_data_d  = mem.rd_data;
                    cpu_rd_ready_d = 1'b1;
                    mem_rd_ack_d   = 1'b1;
                end
            end
            StReturn: begin
                if (cpu.rd_ack) begin
                    state_d        = StIdle;
                    cpu_rd_ready_d = 1'b0;
                    rd_pending_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            rd_pending_q   <= 1'b0;
            mem_addr_q     <= '0;
            mem_wr_data_q  <= '0;
            mem_wr_en_q    <= 1'b0;
            mem_rd_en_q    <= 1'b0;
            mem_rd_ack_q   <= 1'b0;
            cpu_rd_data_q  <= '0;
            cpu_rd_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_pending_q   <= rd_pending_d;
            mem_addr_q     <= mem_addr_d;
            mem_wr_data_q  <= mem_wr_data_d;
            mem_wr_en_q    <= mem_wr_en_d;
            mem_rd_en_q    <= mem_rd_en_d;
            mem_rd_ack_q   <= mem_rd_ack_d;
            cpu_rd_data_q  <= cpu_rd_data_d;
            cpu_rd_ready_q <= cpu_rd_ready_d;
        end
    end

    assign cpu.busy     = cpu_busy;
    assign cpu.rd_data  = cpu_rd_data_q;
    assign cpu.rd_ready = cpu_rd_ready_q;
    assign mem.addr     = mem_addr_q;
    assign mem.wr_data  = mem_wr_data_q;
    assign mem.wr_en    = mem_wr_en_q;
    assign mem.rd_en    = mem_rd_en_q;
    assign mem.rd_ack   = mem_rd_ack_q;

endmodule

// File: tb/tb_ram_req_queue.sv
// Scoreboard bench for ram_req_queue: directed requests push expectations, a monitor checks issues.
module tb_ram_req_queue;
    import ram_pkg::*;

    typedef struct {
        logic        op;
        logic [23:0] addr;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_req_queue_if cpu_bus ();
    ram_req_queue_if mem_bus ();

    ram_req_queue #(
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cpu   (cpu_bus),
        .mem   (mem_bus)
    );

    exp_t        exp_mem[$];
    logic [15:0] exp_cpu[$];
    logic [15:0] model_mem [logic [23:0]];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, ack_cnt = 0;
    int last_wr_cyc = 0;
    int rd_delay = 0;
    logic [23:0] rd_addr = '0;
    logic prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_mem(input logic op);
        exp_t e;
        if (exp_mem.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_mem_issue: got op=%0d addr=0x%0h, expected no issue",
                     op, mem_bus.addr);
        end else begin
            e = exp_mem.pop_front();
            check("mem_op", {31'd0, op}, {31'd0, e.op});
            check("mem_addr", {8'd0, mem_bus.addr}, {8'd0, e.addr});
            if (op == 1'b0) check("mem_wr_data", {16'd0, mem_bus.wr_data}, {16'd0, e.data});
        end
    endtask

    // Monitor: compares every issue strobe and every read return against the scoreboard.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (mem_bus.wr_en && mem_bus.rd_en) check("both_strobes", 32'd1, 32'd0);
            if (mem_bus.wr_en) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                model_mem[mem_bus.addr] = mem_bus.wr_data;
                sb_mem(1'b0);
            end
            if (mem_bus.rd_en) begin
                rd_cnt++;
                rd_delay = 3;
                rd_addr = mem_bus.addr;
                sb_mem(1'b1);
            end
            if (mem_bus.rd_ack) ack_cnt++;
            if (cpu_bus.rd_ready && !prev_ready) begin
                if (exp_cpu.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rd_return: got data 0x%0h, expected none",
                             cpu_bus.rd_data);
                end else begin
                    e = exp_cpu.pop_front();
                    check("cpu_rd_data", {16'd0, cpu_bus.rd_data}, {16'd0, e});
                end
            end
            prev_ready = cpu_bus.rd_ready;
        end
    end

    // Memory model: answers a read with a one-cycle mem_rd_ready three cycles after mem_rd_en.
    initial begin
        mem_bus.rd_ready = 1'b0;
        mem_bus.rd_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_bus.rd_ready = 1'b0;
            if (rd_delay > 0) begin
                rd_delay--;
                if (rd_delay == 0) begin
                    mem_bus.rd_ready = 1'b1;
                    mem_bus.rd_data  = model_mem.exists(rd_addr) ? model_mem[rd_addr] : 16'hDEAD;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int i = 0;
        while (exp_mem.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, exp_mem.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_busy"}, {31'd0, cpu_bus.busy}, 32'd0);
        check({tag, "_cpu_rd_data"}, {16'd0, cpu_bus.rd_data}, 32'd0);
        check({tag, "_cpu_rd_ready"}, {31'd0, cpu_bus.rd_ready}, 32'd0);
        check({tag, "_mem_addr"}, {8'd0, mem_bus.addr}, 32'd0);
        check({tag, "_mem_wr_data"}, {16'd0, mem_bus.wr_data}, 32'd0);
        check({tag, "_mem_wr_en"}, {31'd0, mem_bus.wr_en}, 32'd0);
        check({tag, "_mem_rd_en"}, {31'd0, mem_bus.rd_en}, 32'd0);
        check({tag, "_mem_rd_ack"}, {31'd0, mem_bus.rd_ack}, 32'd0);
    endtask

    initial begin
        int t0, base, found, saw_ready;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, base, found, saw_ready;
        cpu_bus.addr    = '0;
        cpu_bus.wr_data = '0;
        cpu_bus.wr_en   = 1'b0;
        cpu_bus.rd_en   = 1'b0;
        cpu_bus.rd_ack  = 1'b0;
        mem_bus.busy    = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check_all_zero("reset");
        step();
        rst_n = 1'b1;

        // Single write: issue exactly two cycles after the strobe
        step();
        cpu_bus.addr    = 24'h000010;
        cpu_bus.wr_data = 16'h1234;
        cpu_bus.wr_en   = 1'b1;
        t0 = cyc;
        exp_mem.push_back('{1'b0, 24'h000010, 16'h1234});
        @(negedge clk);
        check("wr1_busy", {31'd0, cpu_bus.busy}, 32'd0);
        step();
        cpu_bus.wr_en = 1'b0;
        drain("wr1_drain", 10);
        check("wr1_latency", last_wr_cyc - t0, 32'd2);
        check("wr1_busy_after", {31'd0, cpu_bus.busy}, 32'd0);

        // Fill with controller busy: fifth write dropped, four issued in order
        step();
        mem_bus.busy = 1'b1;
        base = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            cpu_bus.addr    = 24'h000100 + 24'(i);
            cpu_bus.wr_data = 16'hA000 + 16'(i);
            cpu_bus.wr_en   = 1'b1;
            if (i < 4) exp_mem.push_back('{1'b0, 24'h000100 + 24'(i), 16'hA000 + 16'(i)});
            if (i == 3) begin
                @(negedge clk);
                check("fill_busy_before_full", {31'd0, cpu_bus.busy}, 32'd0);
            end
            if (i == 4) begin
                @(negedge clk);
                check("fill_busy_full", {31'd0, cpu_bus.busy}, 32'd1);
            end
            step();
        end
        cpu_bus.wr_en = 1'b0;
        repeat (3) step();
        check("fill_held_busy", {31'd0, cpu_bus.busy}, 32'd1);
        check("fill_no_issue_while_busy", wr_cnt - base, 32'd0);
        mem_bus.busy = 1'b0;
        drain("fill_drain", 40);
        repeat (5) @(negedge clk);
        check("fill_issue_count", wr_cnt - base, 32'd4);
        check("fill_busy_released", {31'd0, cpu_bus.busy}, 32'd0);

        // Write then read same address; late CPU ack holds the return stable
        step();
        base = ack_cnt;
        cpu_bus.addr    = 24'h000020;
        cpu_bus.wr_data = 16'hBEEF;
        cpu_bus.wr_en   = 1'b1;
        exp_mem.push_back('{1'b0, 24'h000020, 16'hBEEF});
        step();
        cpu_bus.wr_en   = 1'b0;
        cpu_bus.wr_data = 16'h0000;
        cpu_bus.rd_en   = 1'b1;
        exp_mem.push_back('{1'b1, 24'h000020, 16'h0000});
        exp_cpu.push_back(16'hBEEF);
        step();
        cpu_bus.rd_en = 1'b0;
        @(negedge clk);
        check("rd_pending_busy", {31'd0, cpu_bus.busy}, 32'd1);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(negedge clk);
            if (cpu_bus.rd_ready) found = 1;
        end
        check("rd_return_seen", found, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("late_ack_data", {16'd0, cpu_bus.rd_data}, 32'hBEEF);
            check("late_ack_ready", {31'd0, cpu_bus.rd_ready}, 32'd1);
            check("late_ack_busy", {31'd0, cpu_bus.busy}, 32'd1);
            @(negedge clk);
        end
        check("mem_rd_ack_pulses", ack_cnt - base, 32'd1);
        step();
        cpu_bus.rd_ack = 1'b1;
        @(negedge clk);
        check("ack_cycle_ready", {31'd0, cpu_bus.rd_ready}, 32'd1);
        step();
        cpu_bus.rd_ack = 1'b0;
        @(negedge clk);
        check("after_ack_ready", {31'd0, cpu_bus.rd_ready}, 32'd0);
        check("after_ack_busy", {31'd0, cpu_bus.busy}, 32'd0);
        check("after_ack_data_kept", {16'd0, cpu_bus.rd_data}, 32'hBEEF);

        // Simultaneous write and read strobes: only the write survives
        step();
        base = rd_cnt;
        cpu_bus.addr    = 24'h000030;
        cpu_bus.wr_data = 16'h5A5A;
        cpu_bus.wr_en   = 1'b1;
        cpu_bus.rd_en   = 1'b1;
        exp_mem.push_back('{1'b0, 24'h000030, 16'h5A5A});
        step();
        cpu_bus.wr_en = 1'b0;
        cpu_bus.rd_en = 1'b0;
        @(negedge clk);
        check("wr_rd_no_pending", {31'd0, cpu_bus.busy}, 32'd0);
        drain("wr_rd_drain", 10);
        repeat (6) @(negedge clk);
        check("wr_rd_no_read_issued", rd_cnt - base, 32'd0);
        check("wr_rd_no_return", {31'd0, cpu_bus.rd_ready}, 32'd0);

        // Reset while waiting for read data; the late mem_rd_ready must be ignored
        step();
        base = rd_cnt;
        cpu_bus.addr  = 24'h000040;
        cpu_bus.rd_en = 1'b1;
        exp_mem.push_back('{1'b1, 24'h000040, 16'h0000});
        step();
        cpu_bus.rd_en = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (rd_cnt != base) found = 1;
        end
        check("rst_rd_issued", found, 32'd1);
        step();
        rst_n = 1'b0;
        base = ack_cnt;
        step();
        rst_n = 1'b1;
        saw_ready = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cpu_bus.rd_ready) saw_ready = 1;
        end
        check("rst_late_ready_fired", rd_delay, 32'd0);
        check("rst_no_mem_rd_ack", ack_cnt - base, 32'd0);
        check("rst_no_cpu_rd_ready", saw_ready, 32'd0);
        check_all_zero("post_rst");

        check("sb_mem_empty", exp_mem.size(), 32'd0);
        check("sb_cpu_empty", exp_cpu.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
